// File: rtl/im_port_arbiter_pkg.sv
// Shared types and default constants for the instruction-memory port arbiter.
package im_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH_RD,
    ST_LOAD_WR,
    ST_LOCKED
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH,
    OWN_LOAD
  } owner_t;

  // Byte address of instruction word 0.
  localparam logic [15:0]  DEF_IM_BASE = 16'h3000;
  // Word-index width; the memory holds 2**IDX_W words.
  localparam int unsigned  DEF_IDX_W   = 10;
  // Word returned for a rejected fetch (addi x0,x0,0).
  localparam logic [31:0]  DEF_NOP     = 32'h0000_0013;

endpackage

// File: rtl/im_port_arbiter_if.sv
// Fetch, loader and memory-side signals of the instruction-memory port arbiter.
interface im_port_arbiter_if
  import im_port_arbiter_pkg::*;
#(
  parameter int unsigned IDX_W = DEF_IDX_W
);
  logic             fetch_req;
  logic [15:0]      fetch_addr;
  logic             fetch_gnt;
  logic             fetch_valid;
  logic [31:0]      fetch_data;
  logic             fetch_err;

  logic             load_req;
  logic [15:0]      load_addr;
  logic [31:0]      load_data;
  logic             load_lock;
  logic             load_gnt;
  logic             load_done;
  logic             load_err;

  logic [IDX_W-1:0] mem_addr;
  logic [31:0]      mem_din;
  logic             mem_we;
  logic [31:0]      mem_dout;

  // Arbiter side.
  modport slave (
    input  fetch_req, fetch_addr, load_req, load_addr, load_data, load_lock, mem_dout,
    output fetch_gnt, fetch_valid, fetch_data, fetch_err,
    output load_gnt, load_done, load_err,
    output mem_addr, mem_din, mem_we
  );

  // Requester / memory side.
  modport master (
    output fetch_req, fetch_addr, load_req, load_addr, load_data, load_lock, mem_dout,
    input  fetch_gnt, fetch_valid, fetch_data, fetch_err,
    input  load_gnt, load_done, load_err,
    input  mem_addr, mem_din, mem_we
  );

endinterface

// File: rtl/im_addr_xlate.sv
// Byte address to instruction word index, with alignment and range check.
module im_addr_xlate
  import im_port_arbiter_pkg::*;
#(
  parameter logic [15:0] IM_BASE = DEF_IM_BASE,
  parameter int unsigned IDX_W   = DEF_IDX_W
) (
  input  logic [15:0]      addr,
  output logic [IDX_W-1:0] idx,
  output logic             ok
);

  localparam logic [16:0] LIMIT = 17'(1) << IDX_W;

  logic [13:0] word_off;

  // Offset from the base in words; only meaningful when addr >= IM_BASE.
  always_comb begin
    word_off = 14'((addr - IM_BASE) >> 2);
    idx      = word_off[IDX_W-1:0];
    ok       = (addr[1:0] == 2'b00) && (addr >= IM_BASE) && ({3'b000, word_off} < LIMIT);
  end

endmodule

// File: rtl/im_port_arbiter.sv
// Sequences the single instruction-memory port between CPU fetch and the program loader.
module im_port_arbiter
  import im_port_arbiter_pkg::*;
#(
  parameter logic [15:0] IM_BASE = DEF_IM_BASE,
  parameter int unsigned IDX_W   = DEF_IDX_W,
  parameter logic [31:0] NOP     = DEF_NOP
) (
  input  logic              clk,
  input  logic              rst,
  im_port_arbiter_if.slave  bus
);

  arb_state_t       state_q;
  owner_t           last_q;
  logic             err_q;
  logic [IDX_W-1:0] addr_q;
  logic [31:0]      data_q;

  logic [IDX_W-1:0] f_idx, l_idx;
  logic             f_ok, l_ok;
  logic             want_f, want_l, gnt_f, gnt_l;
  logic             fetch_valid, load_done, mem_we;
  logic [IDX_W-1:0] mem_addr;
  logic [31:0]      mem_din, fetch_data;

  im_addr_xlate #(.IM_BASE(IM_BASE), .IDX_W(IDX_W)) u_fetch_xlate (
    .addr (bus.fetch_addr),
    .idx  (f_idx),
    .ok   (f_ok)
  );

  im_addr_xlate #(.IM_BASE(IM_BASE), .IDX_W(IDX_W)) u_load_xlate (
    .addr (bus.load_addr),
    .idx  (l_idx),
    .ok   (l_ok)
  );

  // Grant selection: lock keeps fetch out, round-robin on a tie.
  always_comb begin
    want_f = !rst && bus.fetch_req && !bus.load_lock && (state_q != ST_LOCKED);
    want_l = !rst && bus.load_req;
    gnt_f  = want_f;
    gnt_l  = want_l;
    if (want_f && want_l) begin
      gnt_l = (last_q == OWN_FETCH);
      gnt_f = !gnt_l;
    end
  end

  // Memory drive in the grant cycle and response outputs in the following cycle.
  always_comb begin
    mem_we  = gnt_l && l_ok;
    mem_din = mem_we ? bus.load_data : '0;
    if (rst)
      mem_addr = '0;
    else if (gnt_f && f_ok)
      mem_addr = f_idx;
    else if (mem_we)
      mem_addr = l_idx;
    else
      mem_addr = addr_q;

    fetch_valid = !rst && (state_q == ST_FETCH_RD);
    load_done   = !rst && (state_q == ST_LOAD_WR);
    // Read data arrives one cycle after the address, so it passes straight
    // through during FETCH_RD and is held from a register otherwise.
    if (rst)
      fetch_data = '0;
    else if (fetch_valid)
      fetch_data = err_q ? NOP : bus.mem_dout;
    else
      fetch_data = data_q;
  end

  assign bus.fetch_gnt   = gnt_f;
  assign bus.load_gnt    = gnt_l;
  assign bus.fetch_valid = fetch_valid;
  assign bus.fetch_data  = fetch_data;
  assign bus.fetch_err   = fetch_valid && err_q;
  assign bus.load_done   = load_done;
  assign bus.load_err    = load_done && err_q;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_din     = mem_din;
  assign bus.mem_we      = mem_we;

  // FSM, owner history and held output values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= OWN_FETCH;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      addr_q <= mem_addr;
      data_q <= fetch_data;
      if (gnt_f) begin
        state_q <= ST_FETCH_RD;
        last_q  <= OWN_FETCH;
        err_q   <= !f_ok;
      end else if (gnt_l) begin
        state_q <= ST_LOAD_WR;
        last_q  <= OWN_LOAD;
        err_q   <= !l_ok;
      end else begin
        state_q <= bus.load_lock ? ST_LOCKED : ST_IDLE;
        err_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_im_port_arbiter.sv
// Self-checking bench for im_port_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the port.
module tb_im_port_arbiter;

  localparam int unsigned IDX_W = 10;
  localparam int          DEPTH = 1 << IDX_W;
  localparam int          BASE  = 'h3000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  im_port_arbiter_if #(.IDX_W(IDX_W)) bus ();

  im_port_arbiter #(.IM_BASE(16'h3000), .IDX_W(IDX_W), .NOP(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: one-cycle read latency.
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= ram[bus.mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit addr_ok(input logic [15:0] a, output int idx);
    int v;
    v   = int'(a);
    idx = (v - BASE) / 4;
    return (v % 4 == 0) && (v >= BASE) && (idx < DEPTH);
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] ref_mem [DEPTH];
  bit          m_last_load = 0;
  bit          m_locked    = 0;
  bit          p_f = 0, p_l = 0, p_err = 0;
  logic [31:0] p_data = '0;
  logic [31:0] m_fd   = '0;
  int          m_ma   = 0;

  always @(negedge clk) begin : model
    bit rf, rl, gf, gl, fok, lok, we, ev, ed;
    int fi, li, ema;
    logic [31:0] efd;
    ev  = p_f && !rst;
    ed  = p_l && !rst;
    efd = rst ? 32'h0 : (ev ? (p_err ? NOP : p_data) : m_fd);
    fok = addr_ok(bus.fetch_addr, fi);
    lok = addr_ok(bus.load_addr, li);
    rf  = !rst && bus.fetch_req && !(bus.load_lock || m_locked);
    rl  = !rst && bus.load_req;
    if (rf && rl) begin
      gf = m_last_load;
      gl = !m_last_load;
    end else begin
      gf = rf;
      gl = rl;
    end
    we  = gl && lok;
    ema = rst ? 0 : ((gf && fok) ? fi : (we ? li : m_ma));

    chk("fetch_gnt",   32'(bus.fetch_gnt),   32'(gf));
    chk("load_gnt",    32'(bus.load_gnt),    32'(gl));
    chk("mem_we",      32'(bus.mem_we),      32'(we));
    chk("mem_addr",    32'(bus.mem_addr),    32'(ema));
    chk("mem_din",     bus.mem_din,          we ? bus.load_data : 32'h0);
    chk("fetch_valid", 32'(bus.fetch_valid), 32'(ev));
    chk("fetch_err",   32'(bus.fetch_err),   32'(ev && p_err));
    chk("fetch_data",  bus.fetch_data,       efd);
    chk("load_done",   32'(bus.load_done),   32'(ed));
    chk("load_err",    32'(bus.load_err),    32'(ed && p_err));

    if (rst) begin
      m_last_load = 0;
      m_locked    = 0;
      p_f = 0; p_l = 0; p_err = 0;
      m_fd = '0;
      m_ma = 0;
    end else begin
      m_fd  = efd;
      m_ma  = ema;
      p_f   = gf;
      p_l   = gl;
      p_err = gf ? !fok : (gl ? !lok : 1'b0);
      if (gf && fok) p_data = ref_mem[fi];
      if (we) ref_mem[li] = bus.load_data;
      if (gf) m_last_load = 0;
      else if (gl) m_last_load = 1;
      m_locked = bus.load_lock && !gf && !gl;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_addr();
    int unsigned k;
    k = $urandom_range(0, 9);
    case (k)
      0: return 16'(BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3));
      1: return 16'(BASE - 16 + 4 * $urandom_range(0, 3));
      2: return 16'(BASE + 4 * DEPTH + 4 * $urandom_range(0, 3));
      3: return 16'(BASE + 4 * (DEPTH - 1));
      4: return 16'($urandom);
      default: return 16'(BASE + 4 * $urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    logic fg, lg;
    logic [31:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      ram[i] = w;
      ref_mem[i] = w;
    end
    ram[2]     = 32'hDEADBEEF;
    ref_mem[2] = 32'hDEADBEEF;

    rst            = 1'b1;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.load_req   = 1'b0;
    bus.load_addr  = '0;
    bus.load_data  = '0;
    bus.load_lock  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_fetch_valid", 32'(bus.fetch_valid), 32'h0);
    chk("rst_mem_addr",    32'(bus.mem_addr),    32'h0);
    chk("rst_fetch_data",  bus.fetch_data,       32'h0);

    // 1: single fetch of word 2
    step();
    rst = 1'b0;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 16'h3008;
    @(negedge clk);
    chk("t1_gnt",  32'(bus.fetch_gnt), 32'h1);
    chk("t1_addr", 32'(bus.mem_addr),  32'h2);
    step();
    bus.fetch_req = 1'b0;
    @(negedge clk);
    chk("t1_valid", 32'(bus.fetch_valid), 32'h1);
    chk("t1_data",  bus.fetch_data,       32'hDEADBEEF);

    // 2: simultaneous requests alternate, loader first after a fetch
    step();
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 16'h3004;
    bus.load_req   = 1'b1;
    bus.load_addr  = 16'h3010;
    bus.load_data  = 32'h12345678;
    @(negedge clk);
    chk("t2_lgnt", 32'(bus.load_gnt),  32'h1);
    chk("t2_fgnt", 32'(bus.fetch_gnt), 32'h0);
    chk("t2_we",   32'(bus.mem_we),    32'h1);
    chk("t2_addr", 32'(bus.mem_addr),  32'h4);
    step();
    bus.load_req = 1'b0;
    @(negedge clk);
    chk("t2_fgnt2", 32'(bus.fetch_gnt), 32'h1);
    chk("t2_done",  32'(bus.load_done), 32'h1);
    chk("t2_addr2", 32'(bus.mem_addr),  32'h1);
    step();
    bus.load_req  = 1'b1;
    bus.load_addr = 16'h3014;
    bus.load_data = 32'hCAFEF00D;
    @(negedge clk);
    chk("t2_lgnt3", 32'(bus.load_gnt),    32'h1);
    chk("t2_fgnt3", 32'(bus.fetch_gnt),   32'h0);
    chk("t2_fval3", 32'(bus.fetch_valid), 32'h1);
    step();
    bus.load_req = 1'b0;
    @(negedge clk);
    chk("t2_fgnt4", 32'(bus.fetch_gnt), 32'h1);

    // 3: locked burst of four writes, fetch held off until lock released
    step();
    bus.load_lock  = 1'b1;
    bus.fetch_addr = 16'h3010;
    for (int i = 0; i < 4; i++) begin
      bus.load_req  = 1'b1;
      bus.load_addr = 16'(BASE + 4 * i);
      bus.load_data = 32'hA000_0000 + 32'(i);
      @(negedge clk);
      chk("t3_we",   32'(bus.mem_we),    32'h1);
      chk("t3_idx",  32'(bus.mem_addr),  32'(i));
      chk("t3_fgnt", 32'(bus.fetch_gnt), 32'h0);
      step();
    end
    bus.load_req = 1'b0;
    @(negedge clk);
    chk("t3_fgnt_lk", 32'(bus.fetch_gnt), 32'h0);
    step();
    bus.load_lock = 1'b0;
    @(negedge clk);
    chk("t3_fgnt_fall", 32'(bus.fetch_gnt), 32'h0);
    step();
    @(negedge clk);
    chk("t3_fgnt_after", 32'(bus.fetch_gnt), 32'h1);
    chk("t3_addr_after", 32'(bus.mem_addr),  32'h4);
    step();
    bus.fetch_req = 1'b0;
    @(negedge clk);
    chk("t3_rdata", bus.fetch_data, 32'h12345678);

    // 4: misaligned and below-base fetches
    step();
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 16'h3002;
    @(negedge clk);
    chk("t4_gnt",  32'(bus.fetch_gnt), 32'h1);
    chk("t4_addr", 32'(bus.mem_addr),  32'h4);
    step();
    bus.fetch_addr = 16'h2FFC;
    @(negedge clk);
    chk("t4_err1",  32'(bus.fetch_err), 32'h1);
    chk("t4_data1", bus.fetch_data,     NOP);
    chk("t4_addr2", 32'(bus.mem_addr),  32'h4);
    step();
    bus.fetch_req = 1'b0;
    @(negedge clk);
    chk("t4_err2",  32'(bus.fetch_err), 32'h1);
    chk("t4_data2", bus.fetch_data,     NOP);
    step();
    @(negedge clk);
    chk("t4_hold_data", bus.fetch_data,     NOP);
    chk("t4_hold_err",  32'(bus.fetch_err), 32'h0);

    // 5: load one word past the end
    step();
    bus.load_req  = 1'b1;
    bus.load_addr = 16'(BASE + 4 * DEPTH);
    bus.load_data = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("t5_gnt", 32'(bus.load_gnt), 32'h1);
    chk("t5_we",  32'(bus.mem_we),   32'h0);
    step();
    bus.load_req = 1'b0;
    @(negedge clk);
    chk("t5_done", 32'(bus.load_done), 32'h1);
    chk("t5_err",  32'(bus.load_err),  32'h1);
    chk("t5_we2",  32'(bus.mem_we),    32'h0);

    // 6: reset right after a fetch grant discards the response
    step();
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 16'h3008;
    @(negedge clk);
    chk("t6_gnt", 32'(bus.fetch_gnt), 32'h1);
    step();
    rst = 1'b1;
    bus.fetch_req = 1'b0;
    @(negedge clk);
    chk("t6_valid_rst", 32'(bus.fetch_valid), 32'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid", 32'(bus.fetch_valid), 32'h0);
    chk("t6_addr",  32'(bus.mem_addr),    32'h0);
    chk("t6_data",  bus.fetch_data,       32'h0);

    // Randomized traffic: requests held until granted, occasional drops,
    // lock toggling and rare resets.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      fg = bus.fetch_gnt;
      lg = bus.load_gnt;
      step();
      if (!bus.fetch_req || fg || $urandom_range(0, 15) == 0) begin
        bus.fetch_req  = ($urandom_range(0, 3) != 0);
        bus.fetch_addr = rand_addr();
      end
      if (!bus.load_req || lg || $urandom_range(0, 15) == 0) begin
        bus.load_req  = ($urandom_range(0, 2) == 0);
        bus.load_addr = rand_addr();
        bus.load_data = $urandom;
      end
      if ($urandom_range(0, 24) == 0) bus.load_lock = !bus.load_lock;
      rst = ($urandom_range(0, 299) == 0);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
